// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard detection / forwarding unit.
package hazard_pkg;

    // Forwarding select value meaning "take the register-file read data".
    localparam int SEL_RF = 0;

    // Per-stage tracker entry flags. The destination register is kept in a
    // separate array because its width is an instance parameter.
    typedef struct packed {
        logic valid;
        logic wr;
        logic isLoad;
    } trkEntry_t;

    // Width of a forwarding select: 0 = register file, 1..depth = stage index + 1.
    function automatic int selW(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority finder for one operand: picks the youngest in-flight writer of src.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int REG_AW     = 3,
    parameter int LOAD_STAGE = 1,
    localparam int SEL_W     = selW(DEPTH)
) (
    input  trkEntry_t         entFlags [DEPTH],
    input  logic [REG_AW-1:0] entDst   [DEPTH],
    input  logic [REG_AW-1:0] src,
    input  logic              srcUsed,
    output logic [SEL_W-1:0]  sel,
    output logic              ready,
    output logic              hit
);

    // Scan oldest to youngest so the youngest (lowest index) match is written last and wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; without it a
        // no-match path would leave them unassigned and infer latches.
        sel   = SEL_W'(SEL_RF);
        ready = 1'b1;
        hit   = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (srcUsed && entFlags[i].valid && entFlags[i].wr && (entDst[i] == src)) begin
                hit   = 1'b1;
                sel   = SEL_W'(i + 1);
                ready = !entFlags[i].isLoad || (i >= LOAD_STAGE);
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding across DEPTH post-decode stages.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 3,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    localparam int SEL_W     = selW(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic                    issue_wr,
    input  logic                    issue_is_load,
    input  logic [REG_AW-1:0]       issue_dst,
    input  logic [REG_AW-1:0]       src_a,
    input  logic [REG_AW-1:0]       src_b,
    input  logic                    src_a_used,
    input  logic                    src_b_used,
    input  logic [DATA_W-1:0]       rf_a_data,
    input  logic [DATA_W-1:0]       rf_b_data,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    input  logic                    mem_ready,
    input  logic                    flush,
    output logic [SEL_W-1:0]        fwd_a_sel,
    output logic [SEL_W-1:0]        fwd_b_sel,
    output logic [DATA_W-1:0]       fwd_a_data,
    output logic [DATA_W-1:0]       fwd_b_data,
    output logic                    stall,
    output logic                    freeze,
    output logic [15:0]             stall_count,
    output logic                    err
);

    trkEntry_t         entFlags [DEPTH];
    logic [REG_AW-1:0] entDst   [DEPTH];

    logic readyA, readyB;
    logic hitA, hitB;
    logic issueAccept;

    fwd_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_STAGE(LOAD_STAGE)) uMatchA (
        .entFlags (entFlags),
        .entDst   (entDst),
        .src      (src_a),
        .srcUsed  (src_a_used),
        .sel      (fwd_a_sel),
        .ready    (readyA),
        .hit      (hitA)
    );

    fwd_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_STAGE(LOAD_STAGE)) uMatchB (
        .entFlags (entFlags),
        .entDst   (entDst),
        .src      (src_b),
        .srcUsed  (src_b_used),
        .sel      (fwd_b_sel),
        .ready    (readyB),
        .hit      (hitB)
    );

    // A flush kills the decode instruction, so it overrides any load-use stall.
    assign stall       = ((hitA && !readyA) || (hitB && !readyB)) && !flush;
    assign freeze      = !mem_ready;
    assign err         = issue_valid && issue_is_load && !issue_wr;
    assign issueAccept = issue_valid && !stall && !flush;

    // Tracker shift register: advances only while memory is ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the whole tracker is reset, not just the valid bits, so
            // dst values are never X and the match comparators stay clean.
            for (int i = 0; i < DEPTH; i++) begin
                entFlags[i] <= '0;
                entDst[i]   <= '0;
            end
        end else if (mem_ready) begin
            // NOTE: non-blocking assignments let every stage read its
            // predecessor's old value, giving a true shift in one edge.
            for (int i = DEPTH - 1; i > 0; i--) begin
                entFlags[i] <= entFlags[i-1];
                entDst[i]   <= entDst[i-1];
            end
            if (issueAccept) begin
                entFlags[0] <= '{valid: 1'b1, wr: issue_wr, isLoad: issue_is_load};
                entDst[0]   <= issue_dst;
            end else begin
                entFlags[0] <= '0;
                entDst[0]   <= '0;
            end
        end
    end

    // Saturating count of stall cycles that actually advanced the pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stall && mem_ready && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    // Operand data muxes driven by the match selects.
    always_comb begin
        fwd_a_data = rf_a_data;
        fwd_b_data = rf_b_data;
        for (int i = 0; i < DEPTH; i++) begin
            if (fwd_a_sel == SEL_W'(i + 1)) fwd_a_data = stage_data[i*DATA_W +: DATA_W];
            if (fwd_b_sel == SEL_W'(i + 1)) fwd_b_data = stage_data[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed scenarios plus random traffic
// compared against a list-of-instructions reference model.
module tb_hazard_fwd_unit;

    localparam int DATA_W     = 16;
    localparam int REG_AW     = 3;
    localparam int DEPTH      = 3;
    localparam int LOAD_STAGE = 1;
    localparam int SEL_W      = $clog2(DEPTH + 1);

    logic                    clk;
    logic                    rst;
    logic                    issue_valid, issue_wr, issue_is_load;
    logic [REG_AW-1:0]       issue_dst, src_a, src_b;
    logic                    src_a_used, src_b_used;
    logic [DATA_W-1:0]       rf_a_data, rf_b_data;
    logic [DEPTH*DATA_W-1:0] stage_data;
    logic                    mem_ready, flush;
    logic [SEL_W-1:0]        fwd_a_sel, fwd_b_sel;
    logic [DATA_W-1:0]       fwd_a_data, fwd_b_data;
    logic                    stall, freeze, err;
    logic [15:0]             stall_count;

    hazard_fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_wr      (issue_wr),
        .issue_is_load (issue_is_load),
        .issue_dst     (issue_dst),
        .src_a         (src_a),
        .src_b         (src_b),
        .src_a_used    (src_a_used),
        .src_b_used    (src_b_used),
        .rf_a_data     (rf_a_data),
        .rf_b_data     (rf_b_data),
        .stage_data    (stage_data),
        .mem_ready     (mem_ready),
        .flush         (flush),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .fwd_a_data    (fwd_a_data),
        .fwd_b_data    (fwd_b_data),
        .stall         (stall),
        .freeze        (freeze),
        .stall_count   (stall_count),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the in-flight instructions, youngest first (age 0 = EX).
    typedef struct {
        bit              valid;
        bit              wr;
        bit              ld;
        logic [REG_AW-1:0] dst;
    } inst_t;

    inst_t pipe [DEPTH];
    int    mCount;

    function automatic void clearModel();
        for (int i = 0; i < DEPTH; i++) pipe[i] = '{valid: 0, wr: 0, ld: 0, dst: '0};
        mCount = 0;
    endfunction

    // Youngest producer of src; a load younger than LOAD_STAGE has no data yet.
    function automatic void refOperand(input logic [REG_AW-1:0] src, input bit used,
                                       input logic [DATA_W-1:0] rf,
                                       output int sel, output logic [DATA_W-1:0] data, output bit haz);
        sel  = 0;
        data = rf;
        haz  = 0;
        if (used) begin
            for (int age = 0; age < DEPTH; age++) begin
                if (pipe[age].valid && pipe[age].wr && pipe[age].dst == src) begin
                    sel  = age + 1;
                    data = stage_data[age*DATA_W +: DATA_W];
                    haz  = pipe[age].ld && (age < LOAD_STAGE);
                    break;
                end
            end
        end
    endfunction

    // Compare every output against the model for the current inputs.
    task automatic evalCheck(input string tag);
        int sA, sB;
        logic [DATA_W-1:0] dA, dB;
        bit hA, hB;
        #1;
        refOperand(src_a, src_a_used, rf_a_data, sA, dA, hA);
        refOperand(src_b, src_b_used, rf_b_data, sB, dB, hB);
        if (!hA) begin
            check({tag, ".selA"}, 32'(fwd_a_sel), sA);
            check({tag, ".dataA"}, 32'(fwd_a_data), 32'(dA));
        end
        if (!hB) begin
            check({tag, ".selB"}, 32'(fwd_b_sel), sB);
            check({tag, ".dataB"}, 32'(fwd_b_data), 32'(dB));
        end
        check({tag, ".stall"}, 32'(stall), 32'((hA || hB) && !flush));
        check({tag, ".freeze"}, 32'(freeze), 32'(!mem_ready));
        check({tag, ".err"}, 32'(err), 32'(issue_valid && issue_is_load && !issue_wr));
        check({tag, ".count"}, 32'(stall_count), mCount);
    endtask

    // Advance one clock and move the model the same way the pipeline moves.
    task automatic tick();
        int s;
        logic [DATA_W-1:0] d;
        bit hA, hB, stl;
        @(posedge clk);
        refOperand(src_a, src_a_used, rf_a_data, s, d, hA);
        refOperand(src_b, src_b_used, rf_b_data, s, d, hB);
        stl = (hA || hB) && !flush;
        if (rst && mem_ready) begin
            if (stl && mCount < 65535) mCount++;
            for (int i = DEPTH - 1; i > 0; i--) pipe[i] = pipe[i-1];
            if (issue_valid && !stl && !flush)
                pipe[0] = '{valid: 1, wr: issue_wr, ld: issue_is_load, dst: issue_dst};
            else
                pipe[0] = '{valid: 0, wr: 0, ld: 0, dst: '0};
        end
        #1;
    endtask

    task automatic idle();
        issue_valid   = 0;
        issue_wr      = 0;
        issue_is_load = 0;
        issue_dst     = '0;
        src_a         = '0;
        src_b         = '0;
        src_a_used    = 0;
        src_b_used    = 0;
        rf_a_data     = 16'h1111;
        rf_b_data     = 16'h2222;
        stage_data    = '0;
        mem_ready     = 1;
        flush         = 0;
    endtask

    task automatic randomInputs();
        issue_valid   = ($urandom_range(0, 9) < 7);
        issue_wr      = ($urandom_range(0, 9) < 8);
        issue_is_load = ($urandom_range(0, 9) < 3);
        issue_dst     = REG_AW'($urandom_range(0, 3));
        src_a         = REG_AW'($urandom_range(0, 3));
        src_b         = REG_AW'($urandom_range(0, 3));
        src_a_used    = ($urandom_range(0, 3) != 0);
        src_b_used    = ($urandom_range(0, 3) != 0);
        rf_a_data     = DATA_W'($urandom);
        rf_b_data     = DATA_W'($urandom);
        stage_data    = {DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom)};
        mem_ready     = ($urandom_range(0, 99) < 85);
        flush         = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        idle();
        rst = 0;
        clearModel();
        evalCheck("por");
        check("por.sel", 32'(fwd_a_sel), 0);
        check("por.data", 32'(fwd_a_data), 32'h1111);
        @(posedge clk);
        #1 rst = 1;

        // ALU result forwarded from EX with no stall.
        idle(); issue_valid = 1; issue_wr = 1; issue_dst = 3;
        evalCheck("alu_issue"); tick();
        idle(); src_a = 3; src_a_used = 1; stage_data = {16'h0, 16'h0, 16'h1234};
        evalCheck("alu_fwd");
        check("alu_fwd.sel1", 32'(fwd_a_sel), 1);
        check("alu_fwd.d1234", 32'(fwd_a_data), 32'h1234);
        check("alu_fwd.nostall", 32'(stall), 0);
        tick();

        // Load consumed immediately: one stall, then forward from stage 1.
        idle(); issue_valid = 1; issue_wr = 1; issue_is_load = 1; issue_dst = 2;
        evalCheck("ld_issue"); tick();
        idle(); src_b = 2; src_b_used = 1; stage_data = {16'h0, 16'h5678, 16'h0};
        evalCheck("ld_use");
        check("ld_use.stall", 32'(stall), 1);
        tick();
        evalCheck("ld_fwd");
        check("ld_fwd.sel2", 32'(fwd_b_sel), 2);
        check("ld_fwd.d5678", 32'(fwd_b_data), 32'h5678);
        check("ld_fwd.count1", 32'(stall_count), 1);
        tick();

        // Two writers of r4 in flight: the younger one wins.
        idle(); issue_valid = 1; issue_wr = 1; issue_dst = 4;
        tick(); tick();
        idle(); src_a = 4; src_a_used = 1; stage_data = {16'h0, 16'hBBBB, 16'hAAAA};
        evalCheck("youngest");
        check("youngest.sel1", 32'(fwd_a_sel), 1);
        check("youngest.dAAAA", 32'(fwd_a_data), 32'hAAAA);
        tick();

        // Load-use stall while memory is not ready: nothing moves.
        idle(); issue_valid = 1; issue_wr = 1; issue_is_load = 1; issue_dst = 5;
        tick();
        idle(); src_a = 5; src_a_used = 1; mem_ready = 0; stage_data = {16'h0, 16'h0F0F, 16'h0};
        for (int i = 0; i < 3; i++) begin
            evalCheck("frz");
            check("frz.stall", 32'(stall), 1);
            check("frz.freeze", 32'(freeze), 1);
            tick();
            check("frz.count", 32'(stall_count), 1);
        end
        mem_ready = 1;
        evalCheck("frz_rel");
        check("frz_rel.stall", 32'(stall), 1);
        tick();
        evalCheck("frz_fwd");
        check("frz_fwd.sel2", 32'(fwd_a_sel), 2);
        check("frz_fwd.count2", 32'(stall_count), 2);
        tick();

        // Flush beats the load-use stall and kills the decode instruction.
        idle(); issue_valid = 1; issue_wr = 1; issue_is_load = 1; issue_dst = 6;
        tick();
        idle(); src_a = 6; src_a_used = 1; issue_valid = 1; issue_wr = 1; issue_dst = 7; flush = 1;
        evalCheck("flush");
        check("flush.nostall", 32'(stall), 0);
        tick();
        idle(); src_a = 7; src_a_used = 1; rf_a_data = 16'hC0DE;
        evalCheck("flush_kill");
        check("flush_kill.sel0", 32'(fwd_a_sel), 0);
        check("flush_kill.rf", 32'(fwd_a_data), 32'hC0DE);
        tick();

        // Load that writes nothing is an illegal encoding.
        idle(); issue_valid = 1; issue_is_load = 1; issue_wr = 0;
        evalCheck("err");
        check("err.set", 32'(err), 1);
        tick();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            randomInputs();
            evalCheck("rand");
            tick();
        end

        // Asynchronous reset in the middle of traffic.
        randomInputs();
        #2 rst = 0;
        clearModel();
        evalCheck("rst_mid");
        check("rst_mid.stall", 32'(stall), 0);
        check("rst_mid.sel", 32'(fwd_a_sel), 0);
        check("rst_mid.data", 32'(fwd_a_data), 32'(rf_a_data));
        check("rst_mid.count", 32'(stall_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
